// File: rtl/masked_sample_collector.sv
// masked_sample_collector: requests masked Gaussian samples, re-masks each share pair and buffers it in a FWFT FIFO
// Ports: clk/rst (async active-high); enable/reseeding gate new requests; start_sample/sample_valid/
// sample_share0/sample_share1 form the sampler handshake; refresh_mask is the capture-time remask;
// out_valid/out_ready/out_share0/out_share1 form the downstream stream; fifo_count is occupancy;
// busy flags an outstanding request; timeout_err is a sticky abandoned-request flag.
module masked_sample_collector #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          reseeding,
    output logic                          start_sample,
    input  logic                          sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]       sample_share0,
    input  logic [SAMPLE_WIDTH-1:0]       sample_share1,
    input  logic [SAMPLE_WIDTH-1:0]       refresh_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SAMPLE_WIDTH-1:0]       out_share0,
    output logic [SAMPLE_WIDTH-1:0]       out_share1,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_nxt;
    logic [TW-1:0] tmr;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [SAMPLE_WIDTH-1:0] mem0 [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] mem1 [FIFO_DEPTH];
    logic push, pop, expire;
    // Requests are only issued with a free slot, so a capture can never overflow the FIFO.
    always_comb begin
        state_nxt = state;
        push = 1'b0;
        expire = 1'b0;
        case (state)
            IDLE: state_nxt = (enable && !reseeding && count < CW'(FIFO_DEPTH)) ? REQ : IDLE;
            REQ: state_nxt = WAIT;
            WAIT: begin
                push = sample_valid;
                expire = !sample_valid && tmr == TW'(TIMEOUT_CYCLES - 1);
                state_nxt = (push || expire) ? IDLE : WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end
    assign pop = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tmr <= '0;
            timeout_err <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            tmr <= (state == WAIT && state_nxt == WAIT) ? tmr + TW'(1) : '0;
            timeout_err <= timeout_err | expire;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // Each share is remasked independently; their XOR sum is never formed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr] <= sample_share0 ^ refresh_mask;
            mem1[wr_ptr] <= sample_share1 ^ refresh_mask;
        end
    end
    assign start_sample = state == REQ;
    assign busy = state != IDLE;
    assign out_valid = count != '0;
    assign out_share0 = out_valid ? mem0[rd_ptr] : '0;
    assign out_share1 = out_valid ? mem1[rd_ptr] : '0;
    assign fifo_count = count;
endmodule

// File: tb/tb_masked_sample_collector.sv
// tb_masked_sample_collector: directed scoreboard bench for masked_sample_collector
module tb_masked_sample_collector;
    logic clk, rst, enable, reseeding, start_sample, sample_valid;
    logic [15:0] sample_share0, sample_share1, refresh_mask, out_share0, out_share1;
    logic out_valid, out_ready, busy, timeout_err;
    logic [3:0] fifo_count;
    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] x;
    } exp_t;
    exp_t exp_q[$];
    int tests = 0, fails = 0, pulses = 0;
    int resp_delay = 1, stray_req = 0, stray_done = 0, cd = 0;
    logic use_fix = 1'b0;
    logic [15:0] fix_s0 = '0, fix_s1 = '0, fix_m = '0;
    masked_sample_collector dut (
        .clk(clk), .rst(rst), .enable(enable), .reseeding(reseeding),
        .start_sample(start_sample), .sample_valid(sample_valid),
        .sample_share0(sample_share0), .sample_share1(sample_share1),
        .refresh_mask(refresh_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_share0(out_share0), .out_share1(out_share1), .fifo_count(fifo_count),
        .busy(busy), .timeout_err(timeout_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic wait_pulses(input int t);
        int k = 0;
        while (pulses < t && k < 300) begin
            tick();
            k++;
        end
        chk("pulse_wait", 32'(pulses >= t), 1);
    endtask
    task automatic wait_count(input int c);
        int k = 0;
        while (int'(fifo_count) != c && k < 300) begin
            tick();
            k++;
        end
        chk("count_wait", 32'(fifo_count), 32'(c));
    endtask
    // Sampler model and output monitor, both acting on the falling edge.
    initial begin
        logic [15:0] s0, s1, m;
        exp_t e;
        sample_valid = 1'b0;
        sample_share0 = '0;
        sample_share1 = '0;
        refresh_mask = '0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                chk("pop_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pop_s0", 32'(out_share0), 32'(e.e0));
                    chk("pop_s1", 32'(out_share1), 32'(e.e1));
                    chk("xor_inv", 32'(out_share0 ^ out_share1), 32'(e.x));
                end
            end
            if (rst) begin
                cd = 0;
                sample_valid = 1'b0;
                exp_q.delete();
                stray_done = stray_req;
            end else begin
                sample_valid = 1'b0;
                if (stray_req != stray_done) begin
                    sample_share0 = 16'h5555;
                    sample_share1 = 16'h0F0F;
                    sample_valid = 1'b1;
                    stray_done = stray_req;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        s0 = use_fix ? fix_s0 : 16'($urandom);
                        s1 = use_fix ? fix_s1 : 16'($urandom);
                        m = use_fix ? fix_m : 16'($urandom);
                        sample_share0 = s0;
                        sample_share1 = s1;
                        refresh_mask = m;
                        sample_valid = 1'b1;
                        exp_q.push_back('{s0 ^ m, s1 ^ m, s0 ^ s1});
                    end
                end
                if (start_sample) begin
                    pulses++;
                    cd = resp_delay;
                end
            end
        end
    end
    initial begin
        int p;
        rst = 1'b1;
        enable = 1'b0;
        reseeding = 1'b0;
        out_ready = 1'b0;
        tick(2);
        chk("rst_start", 32'(start_sample), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(timeout_err), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_sh0", 32'(out_share0), 0);
        rst = 1'b0;
        tick();
        use_fix = 1'b1;
        fix_s0 = 16'h1234;
        fix_s1 = 16'h1234;
        fix_m = 16'hA5A5;
        resp_delay = 5;
        enable = 1'b1;
        wait_pulses(1);
        enable = 1'b0;
        tick(10);
        chk("single_pulses", 32'(pulses), 1);
        chk("single_count", 32'(fifo_count), 1);
        chk("single_sh0", 32'(out_share0), 32'h B791);
        chk("single_sh1", 32'(out_share1), 32'h B791);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_drain", 32'(fifo_count), 0);
        use_fix = 1'b0;
        resp_delay = 1;
        reseeding = 1'b1;
        enable = 1'b1;
        p = pulses;
        tick(20);
        chk("reseed_block", 32'(pulses), 32'(p));
        reseeding = 1'b0;
        tick(2);
        chk("reseed_release", 32'(pulses), 32'(p + 1));
        enable = 1'b0;
        tick(5);
        out_ready = 1'b1;
        wait_count(0);
        out_ready = 1'b0;
        p = pulses;
        enable = 1'b1;
        wait_count(8);
        tick(20);
        chk("fill_pulses", 32'(pulses - p), 8);
        chk("fill_count", 32'(fifo_count), 8);
        chk("fill_busy", 32'(busy), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_pop", 32'(fifo_count), 7);
        tick(10);
        chk("bp_pulses", 32'(pulses - p), 9);
        chk("bp_refill", 32'(fifo_count), 8);
        enable = 1'b0;
        out_ready = 1'b1;
        wait_count(0);
        out_ready = 1'b0;
        enable = 1'b1;
        wait_count(3);
        enable = 1'b0;
        tick(2);
        resp_delay = 2;
        p = pulses;
        enable = 1'b1;
        wait_pulses(p + 1);
        enable = 1'b0;
        tick();
        chk("simul_pre", 32'(fifo_count), 3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("simul_count", 32'(fifo_count), 3);
        resp_delay = 1;
        p = pulses;
        out_ready = 1'b1;
        enable = 1'b1;
        wait_pulses(p + 20);
        enable = 1'b0;
        tick(10);
        chk("wrap_pulses", 32'(pulses - p), 20);
        wait_count(0);
        chk("wrap_queue", 32'(exp_q.size()), 0);
        out_ready = 1'b0;
        resp_delay = 0;
        enable = 1'b1;
        wait_pulses(pulses + 1);
        enable = 1'b0;
        tick(63);
        chk("to_early", 32'(timeout_err), 0);
        tick();
        chk("to_err", 32'(timeout_err), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_count", 32'(fifo_count), 0);
        resp_delay = 3;
        enable = 1'b1;
        wait_pulses(pulses + 1);
        enable = 1'b0;
        tick(10);
        chk("post_to_count", 32'(fifo_count), 1);
        chk("post_to_err", 32'(timeout_err), 1);
        resp_delay = 5;
        enable = 1'b1;
        wait_pulses(pulses + 1);
        enable = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_start", 32'(start_sample), 0);
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_count", 32'(fifo_count), 0);
        chk("ar_err", 32'(timeout_err), 0);
        chk("ar_sh0", 32'(out_share0), 0);
        chk("ar_sh1", 32'(out_share1), 0);
        tick(2);
        rst = 1'b0;
        p = pulses;
        stray_req++;
        tick(8);
        chk("stray_count", 32'(fifo_count), 0);
        chk("stray_busy", 32'(busy), 0);
        chk("stray_pulses", 32'(pulses), 32'(p));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/masked_sample_collector.md
Name: masked_sample_collector

Overview:
- Initiator/consumer on the request side of the masked Gaussian sampler: pulses start_sample, waits for sample_valid, and captures the Boolean (XOR) share pair.
- Applies a fresh mask refresh at capture, so that share0' = share0^m and share1' = share1^m (the XOR sum is unchanged).
- Buffers refreshed pairs in a first-word-fall-through FIFO and presents them downstream on a valid/ready interface.
- Sits between the sampler and the lattice signing datapath. The XOR sum of the two shares is never formed inside this block.

Parameters:
- SAMPLE_WIDTH, 16, width of each share.
- FIFO_DEPTH, 8, number of share-pair entries; must be a power of 2, minimum 2.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before abandoning a request; minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allow new requests.
- reseeding  in  1  sampler DRBG busy; no request is issued while high.
- start_sample  out  1  single-cycle request pulse to the sampler.
- sample_valid  in  1  sampler result valid.
- sample_share0  in  SAMPLE_WIDTH  sampler share 0.
- sample_share1  in  SAMPLE_WIDTH  sampler share 1.
- refresh_mask  in  SAMPLE_WIDTH  fresh random mask, sampled on the capture cycle.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts the current pair.
- out_share0  out  SAMPLE_WIDTH  head entry, share 0.
- out_share1  out  SAMPLE_WIDTH  head entry, share 1.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of occupied entries.
- busy  out  1  high in REQ or WAIT.
- timeout_err  out  1  sticky; set when a request times out.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE.
  - FIFO pointers and count are cleared.
  - start_sample, out_valid, busy and timeout_err are 0.
  - out_share0/1 and the timeout counter are 0.
  - Reset asserted mid-request discards the request. A sample_valid arriving after reset is ignored.
- FSM states are IDLE, REQ and WAIT.
  - IDLE -> REQ when enable=1, reseeding=0 and fifo_count<FIFO_DEPTH. All three are evaluated on the registered state.
  - REQ: start_sample=1 for exactly one cycle, then WAIT unconditionally.
  - WAIT: the timeout counter increments each cycle.
    - sample_valid=1 -> capture the pair, push it, return to IDLE.
    - Counter reaches TIMEOUT_CYCLES without valid -> set timeout_err, no push, return to IDLE.
- Capture and push:
  - The entry written is {sample_share0^refresh_mask, sample_share1^refresh_mask}, using the values present on the capture edge.
  - Only one request is ever outstanding. Because the IDLE->REQ gate requires space, a push never overflows the FIFO.
- sample_valid outside WAIT is ignored: no push and no error.
- A held-high sample_valid is consumed once per request.
- Request throughput:
  - Minimum request-to-request spacing is 3 cycles: REQ, WAIT, IDLE.
  - Back-to-back operation runs while enable=1 and space is available.
- enable deasserted in REQ or WAIT: the current request completes (capture or timeout), then the FSM stays in IDLE.
- reseeding rising while in WAIT has no effect on the FSM; the timeout still applies.
- FIFO:
  - FWFT. out_share0/1 show the head entry whenever out_valid=1 and are 0 when the FIFO is empty.
  - Pop on out_valid&&out_ready.
- Simultaneous push and pop: fifo_count is unchanged and both pointers advance.
  - This includes count==FIFO_DEPTH-1 with a push, and count==1 with a pop.
  - Push into an empty FIFO: out_valid rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges from 0 to FIFO_DEPTH inclusive.
- timeout_err is cleared only by rst.
- Masking invariant: for every entry, out_share0^out_share1 == sample_share0^sample_share1 at capture.

Test Plan:
- Single request with FIFO_DEPTH=8:
  - Stimulus: enable=1, reseeding=0. The sampler responds 5 cycles after start_sample with share0=16'h1234, share1=16'h1234, and refresh_mask=16'hA5A5.
  - Required response: one start_sample pulse. out_share0=16'hB791, out_share1=16'hB791, fifo_count=1.
- Reseed gating: reseeding=1 for 20 cycles with enable=1 -> no start_sample. The first pulse appears within 2 cycles of reseeding falling.
- Fill and backpressure:
  - Stimulus: out_ready=0 and the sampler always responds in 1 cycle.
  - Required response: exactly 8 start_sample pulses, fifo_count=8, then no further pulses.
  - Follow-up: out_ready=1 for one cycle -> fifo_count=7, and exactly one new request is issued.
- Timeout: the sampler never responds -> timeout_err=1 exactly TIMEOUT_CYCLES=64 cycles after WAIT is entered, with fifo_count=0 and the FSM back in IDLE.
  - Follow-up: a later response completes normally, and timeout_err stays 1.
- Simultaneous events: fifo_count=3, out_ready=1 and a capture on the same edge -> fifo_count stays 3 and data order is preserved. Also cover wrap-around over 20 pairs, with every pair satisfying the XOR invariant.
- Reset mid-WAIT: assert rst between start_sample and sample_valid -> all outputs are 0 immediately (asynchronous). A sample_valid arriving after reset release is not pushed, so fifo_count stays 0.
